// File: rtl/wb_buffer.sv
// Write-back buffer in front of the 8 x 32-bit register file: in-order queue of
// register writes, drained one per cycle, with a combinational forwarding lookup.
module wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic                    clk,
    input  logic                    rstbar,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           in_addr,
    input  logic [31:0]             in_data,
    input  logic                    wr_stall,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic [AW-1:0]           lk_addr,
    output logic                    lk_hit,
    output logic [31:0]             lk_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } entry_t;

    entry_t [DEPTH-1:0] ent;
    logic   [DEPTH-1:0] vld;
    logic   [PW-1:0]    head;
    logic   [PW-1:0]    tail;
    logic   [PW-1:0]    idx;
    logic               push;
    logic               pop;

    // No pass-through: a full buffer refuses input even when it pops this cycle.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign rf_we    = (count != '0) && !wr_stall;
    assign pop      = rf_we;
    assign rf_waddr = (count != '0) ? ent[head].addr : '0;
    assign rf_wdata = (count != '0) ? ent[head].data : '0;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && ent[idx].addr == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = ent[idx].data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            ent   <= '0;
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                ent[tail].addr <= in_addr;
                ent[tail].data <= in_data;
                vld[tail]      <= 1'b1;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: directed scenarios with literal expectations plus a long
// randomized run compared every cycle against a queue-based reference model.
module tb_wb_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rstbar;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_data;
    logic          wr_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic [AW-1:0] lk_addr;
    logic          lk_hit;
    logic [31:0]   lk_data;
    logic [2:0]    count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } ent_t;
    ent_t q[$];

    wb_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstbar(rstbar),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .wr_stall(wr_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs straight from the queue contents.
    task automatic model_check();
        int          sz;
        logic        hit;
        logic [31:0] d;
        sz  = q.size();
        hit = 1'b0;
        d   = '0;
        foreach (q[i]) if (q[i].a == lk_addr) begin hit = 1'b1; d = q[i].d; end
        chk("m_in_ready", in_ready, sz != DEPTH);
        chk("m_rf_we",    rf_we,    (sz != 0) && !wr_stall);
        chk("m_rf_waddr", rf_waddr, (sz != 0) ? q[0].a : '0);
        chk("m_rf_wdata", rf_wdata, (sz != 0) ? q[0].d : '0);
        chk("m_lk_hit",   lk_hit,   hit);
        chk("m_lk_data",  lk_data,  d);
        chk("m_count",    count,    sz);
    endtask

    task automatic model_update();
        int   sz;
        ent_t e;
        sz = q.size();
        if (sz != 0 && !wr_stall) void'(q.pop_front());
        if (in_valid && sz != DEPTH) begin
            e.a = in_addr;
            e.d = in_data;
            q.push_back(e);
        end
    endtask

    // Called in the low phase; returns at the next falling edge.
    task automatic cycle();
        #1 model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic s, input logic [AW-1:0] l);
        in_valid = v; in_addr = a; in_data = d; wr_stall = s; lk_addr = l;
    endtask

    task automatic mid_reset();
        in_valid = 1'b0;
        #2 rstbar = 1'b0;
        #1;
        chk("rst_count",  count,  0);
        chk("rst_rf_we",  rf_we,  0);
        chk("rst_lk_hit", lk_hit, 0);
        chk("rst_lk_data", lk_data, 0);
        chk("rst_in_ready", in_ready, 1);
        q.delete();
        #1 rstbar = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rstbar = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        chk("reset_count",    count,    0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_rf_we",    rf_we,    0);
        chk("reset_lk_hit",   lk_hit,   0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        @(negedge clk);
        rstbar = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_rf_we", rf_we, 0);
            chk("idle_count", count, 0);
            chk("idle_in_ready", in_ready, 1);
            cycle();
        end

        // single write
        drive(1, 3, 32'hDEADBEEF, 0, 3);
        cycle();
        drive(0, 0, 0, 0, 3);
        #1;
        chk("single_rf_we",    rf_we,    1);
        chk("single_rf_waddr", rf_waddr, 3);
        chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_count",    count,    1);
        chk("single_lk_hit",   lk_hit,   1);
        cycle();
        #1;
        chk("single_done_we",    rf_we, 0);
        chk("single_done_count", count, 0);

        // fill under stall, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1, AW'(i), 32'h11 * i, 1, 0);
            cycle();
        end
        drive(1, 5, 32'h55, 1, 0);
        #1;
        chk("full_count",    count,    4);
        chk("full_in_ready", in_ready, 0);
        cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0);
            #1;
            chk("drain_rf_we",    rf_we,    1);
            chk("drain_rf_waddr", rf_waddr, i);
            chk("drain_rf_wdata", rf_wdata, 32'h11 * i);
            cycle();
        end
        #1 chk("drained_count", count, 0);

        // youngest match forwards
        drive(1, 5, 32'hAAAA0000, 1, 5);
        cycle();
        drive(1, 5, 32'hBBBB0000, 1, 5);
        cycle();
        drive(0, 0, 0, 1, 5);
        #1;
        chk("fwd_hit",  lk_hit,  1);
        chk("fwd_data", lk_data, 32'hBBBB0000);
        lk_addr = 6;
        #1;
        chk("fwd_miss_hit",  lk_hit,  0);
        chk("fwd_miss_data", lk_data, 0);
        cycle();
        wr_stall = 1'b0;
        cycle();
        cycle();

        // streaming with simultaneous push/pop and pointer wrap
        for (int i = 1; i <= 10; i++) begin
            drive(1, AW'(i), i, 0, 0);
            #1;
            if (i > 1) begin
                chk("stream_count", count,    1);
                chk("stream_we",    rf_we,    1);
                chk("stream_data",  rf_wdata, i - 1);
            end
            cycle();
        end
        drive(0, 0, 0, 0, 0);
        #1 chk("stream_last", rf_wdata, 10);
        cycle();
        #1 chk("stream_empty", count, 0);

        // reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(i + 2), 32'hC0 + i, 1, 2);
            cycle();
        end
        #1 chk("pre_rst_count", count, 3);
        mid_reset();
        wr_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("post_rst_we", rf_we, 0);
            cycle();
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) < 60), AW'($urandom), $urandom,
                  ($urandom_range(0, 99) < 35), AW'($urandom));
            if ($urandom_range(0, 299) == 0) mid_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_buffer.md
Name: wb_buffer

Overview:
- Write-back buffer sitting directly upstream of the register file, which is built from reg32 words (8 x 32-bit).
- Accepts register write requests from the pipeline with a valid/ready handshake and queues up to DEPTH of them in order.
- Drains at most one request per cycle into the register file's write port (we/addr/data).
- Provides a combinational lookup port so readers can forward pending data that the register file does not hold yet.

Parameters:
DEPTH  4  number of queued write requests (power of two, >=2)
AW  3  register address width (8 architectural registers)

Ports:
clk  input  1  clock; all state updates on rising edge
rstbar  input  1  asynchronous active-low reset
in_valid  input  1  producer has a write request
in_ready  output  1  buffer can accept a request this cycle
in_addr  input  AW  destination register of request
in_data  input  32  write data of request
wr_stall  input  1  register file cannot take a write this cycle
rf_we  output  1  write enable to register file (drives reg32 we of selected word)
rf_waddr  output  AW  register file write address
rf_wdata  output  32  register file write data
lk_addr  input  AW  lookup register address
lk_hit  output  1  a pending entry targets lk_addr
lk_data  output  32  data of youngest pending entry targeting lk_addr
count  output  log2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (rstbar low, async, takes effect immediately without a clock): head=0, tail=0, count=0, all entry-valid bits=0. Outputs during and after reset until the first push: in_ready=1, rf_we=0, lk_hit=0, lk_data=0, rf_waddr=0, rf_wdata=0.
- Reset mid-operation discards all queued entries. No write is issued in the cycle reset is asserted.
- Push: occurs when in_valid && in_ready at the rising edge. The entry at tail is loaded with {in_addr, in_data}, its valid bit is set, and tail increments modulo DEPTH.
- in_ready = (count != DEPTH). There is no pass-through when full, even if a pop happens in the same cycle.
- Pop: rf_we = (count != 0) && !wr_stall, combinational. rf_waddr/rf_wdata always show the head entry; they show 0 when empty. On an edge with rf_we=1, the head entry's valid bit clears and head increments modulo DEPTH.
- Minimum latency from push to rf_we is 1 cycle. An empty buffer never forwards in_data to rf_* in the same cycle.
- Simultaneous push and pop: count unchanged; both pointers advance. This is legal at any count except 0 (nothing to pop) and DEPTH (in_ready=0).
- count: +1 on push-only, -1 on pop-only, otherwise unchanged. It never exceeds DEPTH and never underflows.
- Pointers wrap from DEPTH-1 to 0. Ordering is strictly FIFO, and duplicate addresses are retained as separate entries.
- Lookup is combinational over all valid entries, including the head entry being popped this cycle. It excludes the request being pushed this cycle.
- Multiple matches: the youngest entry (closest behind tail) wins. No match: lk_hit=0, lk_data=0.
- wr_stall held high: buffer fills, in_ready drops at count=DEPTH, contents are held, and lookup remains valid.
- Register address 0 has no special treatment.

Test Plan:
- Reset then idle: rstbar=0 -> count=0, in_ready=1, rf_we=0, lk_hit=0. Release, no input for 5 cycles -> outputs unchanged.
- Single write: push {addr=3, data=0xDEADBEEF}, wr_stall=0 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF for exactly 1 cycle; count 1 then 0.
- Fill and stall: wr_stall=1, push 0x11,0x22,0x33,0x44 to addrs 1..4 -> count=4, in_ready=0, 5th request not accepted. Drop stall -> rf writes 0x11,0x22,0x33,0x44 in order on 4 consecutive cycles.
- Forward youngest: stall, push {5,0xAAAA0000} then {5,0xBBBB0000}, lk_addr=5 -> lk_hit=1, lk_data=0xBBBB0000. lk_addr=6 -> lk_hit=0, lk_data=0.
- Simultaneous push/pop with wrap: stream 10 consecutive requests with data 1..10, wr_stall=0 -> count stays at 1 after the first cycle, pointers wrap, and rf receives data 1..10 in order with no gaps.
- Reset mid-operation: with count=3, assert rstbar=0 between clock edges -> count=0, rf_we=0, lk_hit=0 immediately. After release, no stale entries are ever written.
